// File: rtl/i2s_decoder.sv
// i2s_decoder: I2S receiver. Oversamples BCLK/LRCLK/SDATA on i_mclk, deserialises
// MSB-first words with the standard 1-bit I2S delay, and publishes one stereo pair
// per frame with a one-cycle o_valid strobe.
// Optional feature: define I2S_DECODER_ERR_EN to add o_err, a per-frame short-word flag.
module i2s_decoder #(
  parameter int BITS = 16
) (
  input  logic            i_mclk,
  input  logic            i_rst,
  input  logic            i_bclk,
  input  logic            i_lrclk,
  input  logic            i_sdata,
  output logic [BITS-1:0] o_data_l,
  output logic [BITS-1:0] o_data_r,
`ifdef I2S_DECODER_ERR_EN
  output logic            o_err,
`endif
  output logic            o_valid
);

  // bit_cnt must be able to hold BITS itself, the saturated "word full" value
  localparam int              CW     = $clog2(BITS + 1);
  localparam logic [CW-1:0]   BITS_C = CW'(BITS);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // synchroniser chain; bclk gets a third flop for rise detection
  logic bclk_meta_r, bclk_sync_r, bclk_prev_r;
  logic lrclk_meta_r, lrclk_sync_r;
  logic sdata_meta_r, sdata_sync_r;

  state_t          state_r;
  logic [CW-1:0]   bit_cnt_r;
  logic            lr_prev_r;
  logic [BITS-1:0] shift_r;
  logic [BITS-1:0] hold_l_r;
`ifdef I2S_DECODER_ERR_EN
  logic            err_sticky_r;
`endif

  logic            bclk_rise_s;
  logic            boundary_s;
  logic            short_s;
  logic [BITS-1:0] shift_cap_s;

  // two-flop synchronisers for the asynchronous I2S pins plus bclk edge history
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      bclk_meta_r  <= 1'b0;
      bclk_sync_r  <= 1'b0;
      bclk_prev_r  <= 1'b0;
      lrclk_meta_r <= 1'b1;
      lrclk_sync_r <= 1'b1;
      sdata_meta_r <= 1'b0;
      sdata_sync_r <= 1'b0;
    end else begin
      bclk_meta_r  <= i_bclk;
      bclk_sync_r  <= bclk_meta_r;
      bclk_prev_r  <= bclk_sync_r;
      lrclk_meta_r <= i_lrclk;
      lrclk_sync_r <= lrclk_meta_r;
      sdata_meta_r <= i_sdata;
      sdata_sync_r <= sdata_meta_r;
    end
  end

  // edge/boundary detection and the shift register with the next bit inserted
  always_comb begin
    bclk_rise_s = bclk_sync_r & ~bclk_prev_r;
    boundary_s  = bclk_rise_s & (lrclk_sync_r != lr_prev_r);
    short_s     = (bit_cnt_r < BITS_C);
    shift_cap_s = shift_r;
    for (int i = 0; i < BITS; i++) begin
      if (bit_cnt_r == CW'(BITS - 1 - i)) begin
        shift_cap_s[i] = sdata_sync_r;
      end else begin
        shift_cap_s[i] = shift_r[i];
      end
    end
  end

  // channel FSM: capture bits on BCLK rises, latch left, publish the pair on 1->0
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_SYNC;
      bit_cnt_r    <= {CW{1'b0}};
      lr_prev_r    <= 1'b1;
      shift_r      <= {BITS{1'b0}};
      hold_l_r     <= {BITS{1'b0}};
      o_data_l     <= {BITS{1'b0}};
      o_data_r     <= {BITS{1'b0}};
      o_valid      <= 1'b0;
`ifdef I2S_DECODER_ERR_EN
      err_sticky_r <= 1'b0;
      o_err        <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      if (boundary_s) begin
        // the bit on a boundary edge is the previous word's LSB slot: not stored
        shift_r   <= {BITS{1'b0}};
        bit_cnt_r <= {CW{1'b0}};
        lr_prev_r <= lrclk_sync_r;
        case (state_r)
          ST_SYNC: begin
            if (!lrclk_sync_r) begin
              state_r <= ST_LEFT;
            end else begin
              state_r <= ST_SYNC;
            end
          end
          ST_LEFT: begin
            if (lrclk_sync_r) begin
              hold_l_r <= shift_r;
              state_r  <= ST_RIGHT;
`ifdef I2S_DECODER_ERR_EN
              err_sticky_r <= err_sticky_r | short_s;
`endif
            end else begin
              state_r <= ST_SYNC;
            end
          end
          ST_RIGHT: begin
            if (!lrclk_sync_r) begin
              o_data_l <= hold_l_r;
              o_data_r <= shift_r;
              o_valid  <= 1'b1;
              state_r  <= ST_LEFT;
`ifdef I2S_DECODER_ERR_EN
              // include a short right word ending on this very edge
              o_err        <= err_sticky_r | short_s;
              err_sticky_r <= 1'b0;
`endif
            end else begin
              state_r <= ST_SYNC;
            end
          end
          default: begin
            state_r <= ST_SYNC;
          end
        endcase
      end else if (bclk_rise_s && short_s) begin
        shift_r   <= shift_cap_s;
        bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        // no rise, or word already full: bit_cnt saturates at BITS
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_i2s_decoder.sv
// tb_i2s_decoder: directed I2S frames (32-bit slots, 8 mclk per bit) with
// hand-computed expected samples, latency, period, halt and reset scenarios.
`timescale 1ns/1ps
module tb_i2s_decoder;

  localparam int HALF = 4;

  logic        i_mclk = 1'b0;
  logic        i_rst;
  logic        i_bclk;
  logic        i_lrclk;
  logic        i_sdata;
  logic [15:0] o_data_l;
  logic [15:0] o_data_r;
  logic        o_valid;
`ifdef I2S_DECODER_ERR_EN
  logic        o_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int dbl_cnt = 0;
  int last_valid_cyc = 0;
  int last_rise_cyc = 0;
  int bnd_cyc = 0;
  logic prev_v = 1'b0;

  i2s_decoder #(.BITS(16)) dut (
    .i_mclk  (i_mclk),
    .i_rst   (i_rst),
    .i_bclk  (i_bclk),
    .i_lrclk (i_lrclk),
    .i_sdata (i_sdata),
    .o_data_l(o_data_l),
    .o_data_r(o_data_r),
`ifdef I2S_DECODER_ERR_EN
    .o_err   (o_err),
`endif
    .o_valid (o_valid)
  );

  always #5 i_mclk = ~i_mclk;

  // cycle counter
  always @(posedge i_mclk) cyc <= cyc + 1;

  // strobe monitor: count pulses, note when they happen, catch multi-cycle pulses
  always @(posedge i_mclk) begin
    #1;
    if (o_valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (o_valid && prev_v) dbl_cnt <= dbl_cnt + 1;
    prev_v <= o_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic sd);
    i_bclk  = 1'b0;
    i_lrclk = lr;
    i_sdata = sd;
    repeat (HALF) @(negedge i_mclk);
    i_bclk = 1'b1;
    last_rise_cyc = cyc;
    repeat (HALF) @(negedge i_mclk);
  endtask

  // slot positions p0..p1-1; word is MSB-aligned with dbits valid bits
  task automatic send_slot(input logic lr, input logic [31:0] w, input int dbits,
                           input int p0, input int p1);
    logic sd;
    for (int p = p0; p < p1; p++) begin
      if (p == 0) sd = 1'b1;
      else if (p - 1 < dbits) sd = w[31 - (p - 1)];
      else sd = 1'b0;
      send_bit(lr, sd);
      if (p == 0 && lr == 1'b0) bnd_cyc = last_rise_cyc;
    end
  endtask

  int v0, vr, first_v;

  initial begin
    i_rst = 1'b1; i_bclk = 1'b0; i_lrclk = 1'b1; i_sdata = 1'b0;
    repeat (4) @(negedge i_mclk);
    check_eq("rst_data_l", {16'h0, o_data_l}, 32'h0);
    check_eq("rst_data_r", {16'h0, o_data_r}, 32'h0);
    check_eq("rst_valid", {31'h0, o_valid}, 32'h0);
`ifdef I2S_DECODER_ERR_EN
    check_eq("rst_err", {31'h0, o_err}, 32'h0);
`endif
    i_rst = 1'b0;
    @(negedge i_mclk);

    // 64fs frames: 1234 / ABCD
    send_slot(1'b1, 32'h0, 16, 0, 32);
    send_slot(1'b0, {16'h1234, 16'h0}, 16, 0, 32);
    send_slot(1'b1, {16'hABCD, 16'h0}, 16, 0, 32);
    check_eq("no_valid_first_frame", valid_cnt, 0);
    v0 = valid_cnt;
    send_slot(1'b0, {16'h1234, 16'h0}, 16, 0, 32);
    check_eq("f1_count", valid_cnt, v0 + 1);
    check_eq("f1_data_l", {16'h0, o_data_l}, 32'h1234);
    check_eq("f1_data_r", {16'h0, o_data_r}, 32'hABCD);
    check_eq("f1_latency", last_valid_cyc - bnd_cyc, 3);
    first_v = last_valid_cyc;
    send_slot(1'b1, {16'hABCD, 16'h0}, 16, 0, 32);
    send_slot(1'b0, {24'hFFEEDD, 8'h0}, 24, 0, 32);
    check_eq("f2_count", valid_cnt, v0 + 2);
    check_eq("f2_period", last_valid_cyc - first_v, 512);
    check_eq("f2_latency", last_valid_cyc - bnd_cyc, 3);

    // 24-bit data in 32-bit slots: only top 16 bits kept
    send_slot(1'b1, {24'h112233, 8'h0}, 24, 0, 32);
    send_slot(1'b0, {16'h5A5A, 16'h0}, 16, 0, 32);
    check_eq("w24_data_l", {16'h0, o_data_l}, 32'hFFEE);
    check_eq("w24_data_r", {16'h0, o_data_r}, 32'h1122);
`ifdef I2S_DECODER_ERR_EN
    check_eq("w24_err", {31'h0, o_err}, 32'h0);
`endif

    // short 12-bit right slot: ABC -> ABC0
    send_slot(1'b1, {12'hABC, 20'h0}, 12, 0, 12);
    send_slot(1'b0, {16'h1234, 16'h0}, 16, 0, 32);
    check_eq("short_data_l", {16'h0, o_data_l}, 32'h5A5A);
    check_eq("short_data_r", {16'h0, o_data_r}, 32'hABC0);
`ifdef I2S_DECODER_ERR_EN
    check_eq("short_err", {31'h0, o_err}, 32'h1);
`endif
    send_slot(1'b1, {16'h4321, 16'h0}, 16, 0, 32);
    send_slot(1'b0, {16'h0F0F, 16'h0}, 16, 0, 32);
    check_eq("clean_data_l", {16'h0, o_data_l}, 32'h1234);
    check_eq("clean_data_r", {16'h0, o_data_r}, 32'h4321);
`ifdef I2S_DECODER_ERR_EN
    check_eq("clean_err", {31'h0, o_err}, 32'h0);
`endif

    // BCLK halted mid-right for 10000 mclk while lrclk wiggles
    send_slot(1'b1, {16'hF0F0, 16'h0}, 16, 0, 10);
    v0 = valid_cnt;
    for (int k = 0; k < 10; k++) begin
      repeat (1000) @(negedge i_mclk);
      i_lrclk = ~i_lrclk;
    end
    check_eq("halt_no_valid", valid_cnt, v0);
    check_eq("halt_hold_l", {16'h0, o_data_l}, 32'h1234);
    check_eq("halt_hold_r", {16'h0, o_data_r}, 32'h4321);
    send_slot(1'b1, {16'hF0F0, 16'h0}, 16, 10, 32);
    send_slot(1'b0, {16'h5555, 16'h0}, 16, 0, 32);
    check_eq("resume_count", valid_cnt, v0 + 1);
    check_eq("resume_data_l", {16'h0, o_data_l}, 32'h0F0F);
    check_eq("resume_data_r", {16'h0, o_data_r}, 32'hF0F0);

    // asynchronous reset between mclk edges, mid right channel
    send_slot(1'b1, {16'hAAAA, 16'h0}, 16, 0, 13);
    @(posedge i_mclk);
    #2 i_rst = 1'b1;
    #1;
    check_eq("arst_data_l", {16'h0, o_data_l}, 32'h0);
    check_eq("arst_data_r", {16'h0, o_data_r}, 32'h0);
    check_eq("arst_valid", {31'h0, o_valid}, 32'h0);
    repeat (3) @(negedge i_mclk);
    i_rst = 1'b0;
    vr = valid_cnt;
    send_slot(1'b1, {16'hAAAA, 16'h0}, 16, 13, 32);
    send_slot(1'b0, {16'h8001, 16'h0}, 16, 0, 32);
    send_slot(1'b1, {16'h7FFE, 16'h0}, 16, 0, 32);
    check_eq("rst_no_early_valid", valid_cnt, vr);
    send_slot(1'b0, {16'h8001, 16'h0}, 16, 0, 32);
    check_eq("rst_f1_count", valid_cnt, vr + 1);
    check_eq("rst_f1_data_l", {16'h0, o_data_l}, 32'h8001);
    check_eq("rst_f1_data_r", {16'h0, o_data_r}, 32'h7FFE);
    send_slot(1'b1, {16'h7FFE, 16'h0}, 16, 0, 32);
    send_slot(1'b0, 32'h0, 16, 0, 2);
    check_eq("rst_f2_count", valid_cnt, vr + 2);
    check_eq("rst_f2_data_l", {16'h0, o_data_l}, 32'h8001);
    check_eq("rst_f2_data_r", {16'h0, o_data_r}, 32'h7FFE);

    check_eq("valid_one_cycle", dbl_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
